// File: rtl/dmux8way_rr_arbiter.sv
// Round-robin arbiter that shares one dmux8way-routed resource among 8 requesters.
// Optional burst lock input is compiled in with `define DMUX8_ARB_LOCK_EN.
module dmux8way_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
`ifdef DMUX8_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic       in_valid,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [2:0]       winner;
  logic [2:0]       scan_idx;
  logic             found;
  logic             locked;
  logic             at_max;
  logic             owner_req;
  logic             done_rel;
  logic             max_rel;
  logic             release_now;
  logic             timeout_rel;

`ifdef DMUX8_ARB_LOCK_EN
  assign locked = lock;
`else
  assign locked = 1'b0;
`endif

  // Rotating priority scan: the first requester at or after ptr wins.
  always_comb begin
    found    = 1'b0;
    winner   = ptr;
    scan_idx = ptr;
    for (int i = 0; i < 8; i++) begin
      scan_idx = ptr + 3'(i);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // A held lock masks both the done and the hold-limit release paths.
  assign at_max      = (hold_cnt == CNT_W'(MAX_HOLD));
  assign owner_req   = req[sel];
  assign done_rel    = done && !locked;
  assign max_rel     = at_max && !locked;
  assign release_now = done_rel || !owner_req || max_rel;
  assign timeout_rel = max_rel && !done && owner_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      sel      <= 3'd0;
      in_valid <= 1'b0;
      gnt      <= 8'h00;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sel      <= winner;
            gnt      <= 8'(1) << winner;
            in_valid <= 1'b1;
            busy     <= 1'b1;
            hold_cnt <= CNT_W'(1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            in_valid <= 1'b0;
            gnt      <= 8'h00;
            ptr      <= sel + 3'd1;
            timeout  <= timeout_rel;
            state    <= RELEASE;
          end else if (!at_max) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // gnt is a registered copy of the decoded sel, so the two must never disagree.
  assert property (@(posedge clk) disable iff (!rst_n)
    gnt == (in_valid ? (8'(1) << sel) : 8'h00));
  assert property (@(posedge clk) disable iff (!rst_n) in_valid |-> busy);
`endif

endmodule
